// File: rtl/reg_write_bank.sv
// reg_write_bank: 32x32 register file storage, write port, and last-write bypass record
module reg_write_bank #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    ctrl_writeEnable,
  input  logic [4:0]              ctrl_writeReg,
  input  logic [DATA_W-1:0]       data_writeReg,
  output logic [DATA_W*NREGS-1:0] q,
  output logic [NREGS-1:0]        reg_valid,
  output logic                    last_wr_valid,
  output logic [4:0]              last_wr_reg,
  output logic [DATA_W-1:0]       last_wr_data
);
  logic [NREGS-1:1][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:1]             valid_q, valid_d;
  logic                         lwv_q, lwv_d;
  logic [4:0]                   lwr_q, lwr_d;
  logic [DATA_W-1:0]            lwd_q, lwd_d;
  logic                         acc;
  always_comb begin
    acc = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    regs_d = regs_q;
    valid_d = valid_q;
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = (acc && ctrl_writeReg == 5'(i)) ? data_writeReg : regs_q[i];
      valid_d[i] = valid_q[i] | (acc && ctrl_writeReg == 5'(i));
    end
    lwv_d = acc;
    lwr_d = acc ? ctrl_writeReg : lwr_q;
    lwd_d = acc ? data_writeReg : lwd_q;
  end
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      regs_q <= '0;
      valid_q <= '0;
      lwv_q <= 1'b0;
      lwr_q <= '0;
      lwd_q <= '0;
    end else begin
      regs_q <= regs_d;
      valid_q <= valid_d;
      lwv_q <= lwv_d;
      lwr_q <= lwr_d;
      lwd_q <= lwd_d;
    end
  end
  assign q = {regs_q, {DATA_W{1'b0}}};
  assign reg_valid = {valid_q, 1'b1};
  assign last_wr_valid = lwv_q;
  assign last_wr_reg = lwr_q;
  assign last_wr_data = lwd_q;
endmodule

// File: tb/tb_reg_write_bank.sv
// tb_reg_write_bank: table-driven directed checks of reg_write_bank
module tb_reg_write_bank;
  logic          clock = 1'b0;
  logic          ctrl_reset, ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [1023:0] q;
  logic [31:0]   reg_valid;
  logic          last_wr_valid;
  logic [4:0]    last_wr_reg;
  logic [31:0]   last_wr_data;
  int            errors = 0;
  int            checks = 0;
  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    int          idx;
    logic [31:0] val;
    logic [31:0] vld;
    logic        lwv;
    logic [4:0]  lwr;
    logic [31:0] lwd;
    logic        clean;
  } vec_t;
  vec_t tv[$];
  reg_write_bank dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .q(q),
    .reg_valid(reg_valid),
    .last_wr_valid(last_wr_valid),
    .last_wr_reg(last_wr_reg),
    .last_wr_data(last_wr_data)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    ctrl_reset = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg = wr;
    data_writeReg = wd;
    @(posedge clock);
    #1;
  endtask
  function automatic void add(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                              input int idx, input logic [31:0] val, input logic [31:0] vld,
                              input logic lwv, input logic [4:0] lwr, input logic [31:0] lwd, input logic clean);
    tv.push_back('{rst, we, wr, wd, idx, val, vld, lwv, lwr, lwd, clean});
  endfunction
  initial begin
    logic [1023:0] m;
    add(1'b1, 1'b0, 5'd0,  32'h0,        0,  32'h0,        32'h1,        1'b0, 5'd0,  32'h0,        1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        0,  32'h0,        32'h1,        1'b0, 5'd0,  32'h0,        1'b1);
    add(1'b0, 1'b0, 5'd3,  32'h77,       3,  32'h0,        32'h1,        1'b0, 5'd0,  32'h0,        1'b1);
    add(1'b0, 1'b0, 5'd0,  32'h0,        0,  32'h0,        32'h1,        1'b0, 5'd0,  32'h0,        1'b1);
    add(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5,  32'hDEADBEEF, 32'h21,       1'b1, 5'd5,  32'hDEADBEEF, 1'b1);
    add(1'b0, 1'b0, 5'd9,  32'h11,       5,  32'hDEADBEEF, 32'h21,       1'b0, 5'd5,  32'hDEADBEEF, 1'b1);
    add(1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 0,  32'h0,        32'h21,       1'b0, 5'd5,  32'hDEADBEEF, 1'b0);
    add(1'b0, 1'b1, 5'd31, 32'h1,        31, 32'h1,        32'h80000021, 1'b1, 5'd31, 32'h1,        1'b0);
    add(1'b0, 1'b1, 5'd31, 32'h2,        31, 32'h2,        32'h80000021, 1'b1, 5'd31, 32'h2,        1'b0);
    add(1'b0, 1'b1, 5'd1,  32'h3,        1,  32'h3,        32'h80000023, 1'b1, 5'd1,  32'h3,        1'b0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        31, 32'h2,        32'h80000023, 1'b0, 5'd1,  32'h3,        1'b0);
    add(1'b1, 1'b1, 5'd7,  32'h12345678, 7,  32'h0,        32'h1,        1'b0, 5'd0,  32'h0,        1'b1);
    add(1'b0, 1'b1, 5'd7,  32'h55,       7,  32'h55,       32'h81,       1'b1, 5'd7,  32'h55,       1'b0);
    add(1'b0, 1'b0, 5'd7,  32'h56,       7,  32'h55,       32'h81,       1'b0, 5'd7,  32'h55,       1'b0);
    for (int k = 0; k < tv.size(); k++) begin
      step(tv[k].rst, tv[k].we, tv[k].wr, tv[k].wd);
      chk($sformatf("q[%0d] v%0d", tv[k].idx, k), q[32*tv[k].idx +: 32], tv[k].val);
      chk($sformatf("q0 v%0d", k), q[31:0], 32'h0);
      chk($sformatf("reg_valid v%0d", k), reg_valid, tv[k].vld);
      chk($sformatf("lwv v%0d", k), {31'h0, last_wr_valid}, {31'h0, tv[k].lwv});
      chk($sformatf("lwr v%0d", k), {27'h0, last_wr_reg}, {27'h0, tv[k].lwr});
      chk($sformatf("lwd v%0d", k), last_wr_data, tv[k].lwd);
      if (tv[k].clean) begin
        m = q;
        m[32*tv[k].idx +: 32] = '0;
        chk($sformatf("others zero v%0d", k), {31'h0, |m}, 32'h0);
      end
    end
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd7;
    data_writeReg = 32'h99;
    #2;
    chk("same-cycle old value", q[255:224], 32'h55);
    step(1'b0, 1'b1, 5'd7, 32'h99);
    chk("write lands", q[255:224], 32'h99);
    step(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), i * 32'h01010101);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("walk q[%0d]", i), q[32*i +: 32], i * 32'h01010101);
    chk("walk reg_valid", reg_valid, 32'hFFFFFFFF);
    chk("walk lwv idle", {31'h0, last_wr_valid}, 32'h0);
    chk("walk lwr", {27'h0, last_wr_reg}, 32'd31);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
